// File: rtl/mtr_pwm_pkg.sv
// rtl/mtr_pwm_pkg.sv - shared constants, direction type and duty saturation for the motor PWM stage
package mtr_pwm_pkg;

  localparam int CNT_W  = 11;
  localparam int PERIOD = 2 ** CNT_W;

  typedef enum logic [1:0] {
    FWD  = 2'd0,
    REV  = 2'd1,
    DEAD = 2'd2
  } mtr_dir_t;

  // Clamp a speed magnitude to one full period so duty PERIOD means "always on"
  function automatic logic [11:0] sat(input logic [11:0] spd);
    if (spd < 12'(PERIOD)) return spd;
    else return 12'(PERIOD);
  endfunction

endpackage

// File: rtl/mtr_pwm_chan.sv
// rtl/mtr_pwm_chan.sv - one wheel: period-aligned duty latch, reversal dead-time FSM, registered H-bridge outputs
module mtr_pwm_chan
  import mtr_pwm_pkg::*;
#(
  parameter int DEAD_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt,
  input  logic             bnd,
  input  logic [11:0]      spd,
  input  logic             rev,
  output logic             pwm_frwrd,
  output logic             pwm_rev,
  output logic             dead
);

  localparam logic [11:0] DEAD_LIM = 12'(DEAD_CYC);
  localparam logic [11:0] DEAD_MAX = 12'hFFF;

  mtr_dir_t    state;
  mtr_dir_t    state_nxt;
  logic [11:0] duty_q;
  logic        req_q;
  logic        req_nxt;
  logic [11:0] dead_cnt;
  logic        on;
  logic        frwrd_d;
  logic        rev_d;
  logic        dead_d;

  // Direction as it stands after this edge's latch; the FSM acts on the freshly
  // sampled request so a reversal starts its dead time at the same boundary.
  assign req_nxt = bnd ? rev : req_q;
  assign on      = ({1'b0, cnt} < duty_q);

  // Duty and direction request only change at the period boundary (glitch-free updates)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      req_q  <= 1'b0;
    end else if (bnd) begin
      duty_q <= sat(spd);
      req_q  <= rev;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FWD;
    else        state <= state_nxt;
  end

  // Next state: direction changes always pass through DEAD, exits only on a boundary
  always_comb begin
    state_nxt = state;
    if (bnd) begin
      case (state)
        FWD:     if (req_nxt)              state_nxt = DEAD;
        REV:     if (!req_nxt)             state_nxt = DEAD;
        DEAD:    if (dead_cnt >= DEAD_LIM) state_nxt = req_nxt ? REV : FWD;
        default:                           state_nxt = FWD;
      endcase
    end
  end

  // Dead-time counter: cleared on DEAD entry, saturating count while in DEAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dead_cnt <= '0;
    end else if (state != DEAD) begin
      if (state_nxt == DEAD) dead_cnt <= '0;
    end else if (dead_cnt != DEAD_MAX) begin
      dead_cnt <= dead_cnt + 12'd1;
    end
  end

  // Output decode: each drive depends on a single state, so the pair is mutually exclusive
  always_comb begin
    frwrd_d = (state == FWD) && on;
    rev_d   = (state == REV) && on;
    dead_d  = (state == DEAD);
  end

  // Registered gate-drive outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_frwrd <= 1'b0;
      pwm_rev   <= 1'b0;
      dead      <= 1'b0;
    end else begin
      pwm_frwrd <= frwrd_d;
      pwm_rev   <= rev_d;
      dead      <= dead_d;
    end
  end

endmodule

// File: rtl/mtr_pwm_drv.sv
// rtl/mtr_pwm_drv.sv - two-wheel PWM drive: shared period counter feeding left and right channels
module mtr_pwm_drv
  import mtr_pwm_pkg::*;
#(
  parameter int DEAD_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_spd,
  input  logic        lft_rev,
  input  logic [11:0] rght_spd,
  input  logic        rght_rev,
  output logic        PWM_frwrd_lft,
  output logic        PWM_rev_lft,
  output logic        PWM_frwrd_rght,
  output logic        PWM_rev_rght,
  output logic        dead_lft,
  output logic        dead_rght
);

  logic [CNT_W-1:0] cnt;
  logic             bnd;

  assign bnd = &cnt;

  // Free-running period counter shared by both wheels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  mtr_pwm_chan #(.DEAD_CYC(DEAD_CYC)) u_lft (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt       (cnt),
    .bnd       (bnd),
    .spd       (lft_spd),
    .rev       (lft_rev),
    .pwm_frwrd (PWM_frwrd_lft),
    .pwm_rev   (PWM_rev_lft),
    .dead      (dead_lft)
  );

  mtr_pwm_chan #(.DEAD_CYC(DEAD_CYC)) u_rght (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt       (cnt),
    .bnd       (bnd),
    .spd       (rght_spd),
    .rev       (rght_rev),
    .pwm_frwrd (PWM_frwrd_rght),
    .pwm_rev   (PWM_rev_rght),
    .dead      (dead_rght)
  );

endmodule

// File: doc/mtr_pwm_drv.md
Name: mtr_pwm_drv

Overview:
Motor-drive stage that sits directly downstream of the balance controller. It consumes the per-wheel speed magnitude and reverse flag for the left and right wheels. For each wheel it produces a forward/reverse pair of PWM signals for the H-bridge gate drivers. It enforces glitch-free duty updates, reversal dead-time, and a guarantee that a forward/reverse pair is never high together.

Parameters:
CNT_W, 11, PWM counter width; period = 2**CNT_W clocks (2048).
DEAD_CYC, 64, minimum number of clocks with both outputs of a wheel low on a direction reversal; legal range 1..4095.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
lft_spd  input  12  left wheel speed magnitude, unsigned
lft_rev  input  1  left direction request; 1 = reverse
rght_spd  input  12  right wheel speed magnitude, unsigned
rght_rev  input  1  right direction request; 1 = reverse
PWM_frwrd_lft  output  1  left bridge forward drive
PWM_rev_lft  output  1  left bridge reverse drive
PWM_frwrd_rght  output  1  right bridge forward drive
PWM_rev_rght  output  1  right bridge reverse drive
dead_lft  output  1  high while the left channel is in DEAD
dead_rght  output  1  high while the right channel is in DEAD

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - cnt = 0; both channels in state FWD; duty_q = 0; dead_cnt = 0.
  - All six outputs = 0.
- Period counter:
  - cnt[CNT_W-1:0] is free-running, incrementing every clock and wrapping 2047 -> 0.
  - It is shared by both channels.
  - Period boundary ("bnd") = the cycle in which cnt == 2047.
- Duty saturation:
  - sat = spd if spd < 2048, else 2048 (12-bit value).
  - duty 0 -> output always low; duty 2048 -> output always high.
- Compare: on = ({1'b0,cnt} < duty_q).
- Sampling at bnd:
  - Each channel latches duty_q <= sat(spd) and req_q <= rev.
  - Changes to spd/rev mid-period have no effect until the next bnd.
- Per-channel FSM (states FWD, REV, DEAD):
  - FWD/REV at bnd: if req_q direction == current state, stay. Otherwise go to DEAD and clear dead_cnt to 0.
  - DEAD: dead_cnt increments, saturating at 4095.
  - DEAD exit: at the first bnd where dead_cnt >= DEAD_CYC, go to FWD or REV according to the freshly latched req_q.
    - If req_q reverted to the original direction, the channel returns there, but only after the dead time has elapsed.
  - With the default DEAD_CYC, DEAD lasts exactly one full period (2048 clocks). A value > 2047 gives two periods.
- Outputs (registered, 1-clock latency from the cnt compare):
  - FWD: frwrd = on, rev = 0.
  - REV: frwrd = 0, rev = on.
  - DEAD: both 0, dead_x = 1.
- Invariant: frwrd and rev of a wheel are never 1 in the same cycle, including the transition cycles.
- A reversal request is honoured even when duty is 0 (DEAD is still entered).
- Left and right channels are fully independent apart from the shared cnt.
- Reset asserted mid-operation (including mid-DEAD) returns everything to reset values immediately. After release, counting restarts from cnt = 0.

Decomposition:
- Package mtr_pwm_pkg holds:
  - CNT_W and PERIOD constants.
  - typedef enum logic [1:0] {FWD, REV, DEAD} mtr_dir_t.
  - The sat function.
- Top module mtr_pwm_drv contains the shared cnt and bnd decode, plus two instances of one sub-module.
- Sub-module mtr_pwm_chan (parameter DEAD_CYC) contains duty_q, req_q, the FSM, dead_cnt and the registered outputs.

Test Plan:
1. lft_spd=1024, lft_rev=0, held 3 periods -> from the 2nd period, PWM_frwrd_lft high exactly 1024 of 2048 clocks (cnt 0..1023, +1 clk latency); PWM_rev_lft = 0 throughout.
2. rght_spd=0, then rght_spd=3000 -> outputs low; after the next bnd, PWM_frwrd_rght constantly high (saturated at 2048), no low cycles.
3. lft_spd=512, lft_rev flips 0->1 at cnt=300 -> current period stays forward at 512. The next period has both outputs low and dead_lft=1 for 2048 clocks. The following period has PWM_rev_lft high for 512 clocks.
4. rght_spd changes 512->1536 at cnt=100 -> remainder of the period uses 512; the next period uses 1536. No runt pulse occurs at the change.
5. Reversal and un-reversal: lft_rev 0->1, then back to 0 during DEAD -> after DEAD ends, the channel returns to FWD. The rev output never asserts.
6. Assert rst_n low mid-DEAD -> all outputs 0 and dead_x 0 within the same cycle (asynchronous). After release, cnt starts at 0 in FWD. A concurrent assertion that frwrd&rev is never 1 holds for the whole run.
